key_sched_ctrl: RTL and testbench

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

---
 rtl/key_sched_ctrl_pkg.sv | 6 +
 rtl/key_sched_ctrl_lifo.sv | 20 ++
 rtl/key_sched_ctrl.sv | 70 +++++++
 tb/tb_key_sched_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/key_sched_ctrl_pkg.sv
// key_sched_ctrl_pkg: shared key-storage constants and controller state encoding
package key_sched_ctrl_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 44;
  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_e;
endpackage

// File: rtl/key_sched_ctrl_lifo.sv
// circular_lifo: shift-register stack; push inserts on top, rotate moves the top to the bottom
module circular_lifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 44
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (en_i)
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= push_i ? (i == 0 ? data_i : mem_q[(i + DEPTH - 1) % DEPTH]) : mem_q[(i + 1) % DEPTH];
  assign top_o = mem_q[0];
endmodule

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: loads a key schedule from the expander, replays it in reverse word order
module key_sched_ctrl
  import key_sched_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             kw_valid,
  input  logic [WIDTH-1:0] kw_data,
  output logic             kw_ready,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [WIDTH-1:0] rk_data,
  output logic             rk_last,
  output logic             pass_done,
  output logic [CW-1:0]    word_idx
);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  state_e state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic pass_done_q, push, pop;
  assign kw_ready  = state_q == LOAD;
  assign rk_valid  = state_q == SERVE && !load_start;
  assign rk_last   = state_q == SERVE && idx_q == LAST;
  assign push      = kw_ready && kw_valid;
  assign pop       = rk_valid && rk_ready;
  assign pass_done = pass_done_q;
  assign word_idx  = idx_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (load_start) begin
        state_d = LOAD;
        idx_d   = '0;
      end
      LOAD: if (push) begin
        state_d = idx_q == LAST ? SERVE : LOAD;
        idx_d   = idx_q == LAST ? '0 : idx_q + CW'(1);
      end
      SERVE: if (load_start) begin
        state_d = LOAD;
        idx_d   = '0;
      end else if (pop) idx_d = rk_last ? '0 : idx_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_done_q <= pop && rk_last;
    end
  circular_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_store (
    .clk    (clk),
    .rst    (!rst_n),
    .en_i   (push || pop),
    .push_i (push),
    .data_i (kw_data),
    .top_o  (rk_data)
  );
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: directed and randomized checks against a queue-based schedule model
module tb_key_sched_ctrl;
  localparam int W = 32, D = 4, CW = $clog2(D);
  logic clk = 0, rst_n = 0, load_start = 0, kw_valid = 0, rk_ready = 0;
  logic [W-1:0] kw_data = '0;
  logic kw_ready, rk_valid, rk_last, pass_done;
  logic [W-1:0] rk_data;
  logic [CW-1:0] word_idx;
  int tests = 0, fails = 0;
  int m_mode, m_idx;
  logic m_pd;
  logic [W-1:0] m_top;
  logic [W-1:0] m_words[$];
  logic [W-1:0] m_sched[D];

  key_sched_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .kw_valid(kw_valid),
    .kw_data(kw_data), .kw_ready(kw_ready), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_last(rk_last), .pass_done(pass_done), .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_pd = 0; m_top = '0;
    m_words.delete();
  endtask

  task automatic check_all(string t);
    chk({t, ".kw_ready"}, W'(kw_ready), W'(m_mode == 1));
    chk({t, ".rk_valid"}, W'(rk_valid), W'(m_mode == 2 && !load_start));
    chk({t, ".rk_last"}, W'(rk_last), W'(m_mode == 2 && m_idx == D - 1));
    chk({t, ".pass_done"}, W'(pass_done), W'(m_pd));
    chk({t, ".word_idx"}, W'(word_idx), W'(m_idx));
    chk({t, ".rk_data"}, rk_data, m_top);
  endtask

  // drive one cycle of inputs, check outputs before the edge, then advance the model
  task automatic step(string t, logic ls, logic kv, logic [W-1:0] kd, logic rr);
    logic push, pop;
    @(negedge clk);
    load_start = ls; kw_valid = kv; kw_data = kd; rk_ready = rr;
    #1 check_all(t);
    push = m_mode == 1 && kv;
    pop  = m_mode == 2 && !ls && rr;
    m_pd = pop && m_idx == D - 1;
    if (m_mode == 0) begin
      if (ls) begin m_mode = 1; m_idx = 0; m_words.delete(); end
    end else if (m_mode == 1) begin
      if (push) begin
        m_words.push_back(kd);
        m_top = kd;
        if (m_idx == D - 1) begin
          for (int i = 0; i < D; i++) m_sched[i] = m_words[i];
          m_mode = 2; m_idx = 0;
        end else m_idx++;
      end
    end else if (ls) begin
      m_mode = 1; m_idx = 0; m_words.delete();
    end else if (pop) begin
      m_idx = (m_idx + 1) % D;
      m_top = m_sched[D - 1 - m_idx];
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all("reset");
    rst_n = 1;
    step("idle_kv", 0, 1, 32'h1111, 1);
    step("start", 1, 0, 0, 0);
    step("pushA", 0, 1, 32'hA, 0);
    step("pushB", 0, 1, 32'hB, 0);
    step("pushC", 0, 1, 32'hC, 0);
    step("pushD", 0, 1, 32'hD, 0);
    for (int i = 0; i < 2 * D; i++) step("pass", 0, 0, 0, 1);
    step("popD", 0, 1, 32'h5555, 1);
    step("reload", 1, 0, 0, 1);
    step("pushE", 0, 1, 32'hE, 0);
    step("gap0", 1, 0, 32'h77, 1);
    step("pushF", 0, 1, 32'hF, 0);
    step("gap1", 0, 0, 32'h88, 0);
    step("pushG", 0, 1, 32'h10, 0);
    step("gap2", 0, 0, 0, 0);
    step("pushH", 0, 1, 32'h11, 0);
    step("hold", 0, 1, 32'h99, 0);
    for (int i = 0; i < D + 1; i++) step("serve2", 0, 1, $urandom, 1);
    step("mid", 0, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 0;
    model_reset();
    #1 check_all("async_rst");
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) step("post_rst", 0, 1, $urandom, 1);
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(15) == 0, $urandom_range(1), $urandom, $urandom_range(9) < 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
